// File: rtl/fb_stream_axi_writer_if.sv
// Command, AXIS pixel stream and AXI4 write-channel bundle for fb_stream_axi_writer.
// master = the writer block, slave = its environment (command source, stream source, memory).
interface fb_stream_axi_writer_if #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STREAM_WIDTH = 32
);
  logic                        s_avalid;
  logic                        s_aready;
  logic [ADDR_WIDTH-1:0]       s_aaddr;
  logic [ADDR_WIDTH-1:0]       s_abytes;

  logic                        s_axis_tvalid;
  logic                        s_axis_tready;
  logic                        s_axis_tlast;
  logic [STREAM_WIDTH-1:0]     s_axis_tdata;
  logic [STREAM_WIDTH/8-1:0]   s_axis_tstrb;

  logic                        m_axi_awvalid;
  logic                        m_axi_awready;
  logic [ADDR_WIDTH-1:0]       m_axi_awaddr;
  logic [7:0]                  m_axi_awlen;
  logic [2:0]                  m_axi_awsize;
  logic [1:0]                  m_axi_awburst;

  logic                        m_axi_wvalid;
  logic                        m_axi_wready;
  logic                        m_axi_wlast;
  logic [STREAM_WIDTH-1:0]     m_axi_wdata;
  logic [STREAM_WIDTH/8-1:0]   m_axi_wstrb;

  logic                        m_axi_bvalid;
  logic                        m_axi_bready;
  logic [1:0]                  m_axi_bresp;

  modport master (
    input  s_avalid, s_aaddr, s_abytes,
    output s_aready,
    input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tstrb,
    output s_axis_tready,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wlast, m_axi_wdata, m_axi_wstrb,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp,
    output m_axi_bready
  );

  modport slave (
    output s_avalid, s_aaddr, s_abytes,
    input  s_aready,
    output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tstrb,
    input  s_axis_tready,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wlast, m_axi_wdata, m_axi_wstrb,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp,
    input  m_axi_bready
  );
endinterface

// File: rtl/fb_stream_axi_writer.sv
// Framebuffer commit writer: command + AXIS stream -> AXI4 INCR bursts, one outstanding.
// Optional macro FB_STREAM_AXI_WRITER_RESP_CHECK_EN enables the sticky bresp error flag.
module fb_stream_axi_writer #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned STREAM_WIDTH    = 32,
  parameter int unsigned MAX_BURST_BEATS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fb_stream_axi_writer_if.master bus,
  output logic                  busy,
  output logic                  error
);
  localparam int unsigned BPB = STREAM_WIDTH / 8;
  localparam int unsigned OFF = $clog2(BPB);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF;
  localparam logic [12:0] MAX_BEATS = 13'(MAX_BURST_BEATS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [8:0]            burst_q, burst_d;
  logic [8:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH-1:0] cmd_beats;
  logic [12:0]           page_beats;
  logic [12:0]           cap_beats;
  logic [8:0]            burst_now;
  logic                  beat_last;

  logic                  aready_c;
  logic                  tready_c;
  logic                  awvalid_c;
  logic                  wvalid_c;
  logic [STREAM_WIDTH-1:0]   wdata_c;
  logic [STREAM_WIDTH/8-1:0] wstrb_c;
  logic                  bready_c;
  logic                  w_fire;

  assign cmd_beats  = ADDR_WIDTH'(({1'b0, bus.s_abytes} + (ADDR_WIDTH+1)'(BPB - 1)) >> OFF);

  // Beats left before the next 4 KiB boundary; addr_q is always beat-aligned.
  assign page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> OFF;
  assign cap_beats  = (page_beats < MAX_BEATS) ? page_beats : MAX_BEATS;
  assign burst_now  = (rem_q < ADDR_WIDTH'(cap_beats)) ? rem_q[8:0] : cap_beats[8:0];
  assign beat_last  = (cnt_q == burst_q - 9'd1);

  assign bus.s_aready      = aready_c;
  assign bus.s_axis_tready = tready_c;
  assign bus.m_axi_awvalid = awvalid_c;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awlen   = 8'(burst_now - 9'd1);
  assign bus.m_axi_awsize  = 3'(OFF);
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_wvalid  = wvalid_c;
  assign bus.m_axi_wdata   = wdata_c;
  assign bus.m_axi_wstrb   = wstrb_c;
  assign bus.m_axi_wlast   = (state_q == S_DATA) && beat_last;
  assign bus.m_axi_bready  = bready_c;
  assign busy              = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    aready_c  = 1'b0;
    tready_c  = 1'b0;
    awvalid_c = 1'b0;
    wvalid_c  = 1'b0;
    wdata_c   = '0;
    wstrb_c   = '0;
    bready_c  = 1'b0;
    w_fire    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        aready_c = 1'b1;
        if (bus.s_avalid) begin
          addr_d  = bus.s_aaddr & ALIGN_MASK;
          rem_d   = cmd_beats;
          done_d  = 1'b0;
          state_d = S_ADDR;
        end
      end

      // A zero-length command passes through here once so busy is seen for a cycle.
      S_ADDR: begin
        if (rem_q == '0) begin
          state_d = S_IDLE;
        end else begin
          awvalid_c = 1'b1;
          if (bus.m_axi_awready) begin
            burst_d = burst_now;
            cnt_d   = '0;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (done_q) begin
          wvalid_c = 1'b1;
        end else begin
          wvalid_c = bus.s_axis_tvalid;
          tready_c = bus.m_axi_wready;
          wdata_c  = bus.s_axis_tdata;
          wstrb_c  = bus.s_axis_tstrb;
        end
        w_fire = wvalid_c && bus.m_axi_wready;
        if (w_fire) begin
          cnt_d = cnt_q + 9'd1;
          if (!done_q && bus.s_axis_tlast) begin
            done_d = 1'b1;
          end
          if (beat_last) begin
            state_d = S_RESP;
          end
        end
      end

      S_RESP: begin
        bready_c = 1'b1;
        if (bus.m_axi_bvalid) begin
          addr_d = addr_q + (ADDR_WIDTH'(burst_q) << OFF);
          rem_d  = rem_q - ADDR_WIDTH'(burst_q);
          if (done_q) begin
            state_d = S_IDLE;
          end else if (rem_d != '0) begin
            state_d = S_ADDR;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        tready_c = 1'b1;
        if (bus.s_axis_tvalid && bus.s_axis_tlast) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef FB_STREAM_AXI_WRITER_RESP_CHECK_EN
  logic error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if (bready_c && bus.m_axi_bvalid && (bus.m_axi_bresp != 2'b00)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_bresp;

  assign unused_bresp = ^bus.m_axi_bresp;
  assign error        = 1'b0;
`endif

endmodule
